// File: rtl/clk_div_ratio_sequencer_pkg.sv
// Shared definitions for the divider ratio sequencer: state encoding and
// default parameter values.
package clk_div_ratio_sequencer_pkg;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE   = 2'd0;
  localparam seq_state_t ST_RUN    = 2'd1;
  localparam seq_state_t ST_PEND   = 2'd2;
  localparam seq_state_t ST_SETTLE = 2'd3;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_RESET_RATIO    = 3;
  localparam int DEF_SETTLE_PERIODS = 2;

  // Requests are only taken where applying them cannot disturb a running change.
  function automatic logic state_accepts(input seq_state_t st);
    return (st == ST_IDLE) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/clk_div_ratio_sequencer_boundary_tracker.sv
// Shadow of the programmable divider: counter and output phase advance in
// lockstep with the real divider so toggle edges are known a cycle ahead.
module clk_div_ratio_sequencer_boundary_tracker #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             clr,
  input  logic [WIDTH-1:0] ratio,
  output logic             boundary,
  output logic             rise_edge,
  output logic             div_phase
);

  logic [WIDTH-1:0] cnt;

  assign boundary  = enable && (cnt >= ratio);
  assign rise_edge = boundary && !div_phase;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt       <= '0;
      div_phase <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
    end else if (enable) begin
      if (boundary) begin
        cnt       <= '0;
        div_phase <= ~div_phase;
      end else begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/clk_div_ratio_sequencer.sv
// Sequencer driving the programmable divider's enable and ratio so that ratio
// changes land on toggle edges and stops park the divided clock low.
//
//   state  | meaning
//   IDLE   | divider stopped, clk_out parked low, accepts start
//   RUN    | running and locked, accepts ratio change or stop
//   PEND   | request latched, waiting for a qualifying toggle edge
//   SETTLE | new ratio applied, counting full periods before lock
module clk_div_ratio_sequencer
  import clk_div_ratio_sequencer_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int RESET_RATIO    = DEF_RESET_RATIO,
  parameter int SETTLE_PERIODS = DEF_SETTLE_PERIODS
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_stop,
  input  logic [WIDTH-1:0] req_ratio,
  output logic             req_ready,
  output logic             div_enable,
  output logic [WIDTH-1:0] div_ratio,
  output logic             div_phase,
  output logic             locked,
  output logic [1:0]       state
);

  localparam int SW = $clog2(SETTLE_PERIODS + 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_PERIODS - 1);
  localparam logic [WIDTH-1:0] RATIO_RST   = WIDTH'(RESET_RATIO);

  logic             accept;
  logic             start_clr;
  logic             boundary;
  logic             rise_edge;
  logic             pend_stop;
  logic [WIDTH-1:0] pend_ratio;
  logic [SW-1:0]    settle_cnt;

  assign req_ready = state_accepts(state);
  assign accept    = req_valid && req_ready;
  assign start_clr = (state == ST_IDLE) && accept && !req_stop;

  clk_div_ratio_sequencer_boundary_tracker #(
    .WIDTH (WIDTH)
  ) u_tracker (
    .clk_in    (clk_in),
    .rst       (rst),
    .enable    (div_enable),
    .clr       (start_clr),
    .ratio     (div_ratio),
    .boundary  (boundary),
    .rise_edge (rise_edge),
    .div_phase (div_phase)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= ST_IDLE;
      div_enable <= 1'b0;
      div_ratio  <= RATIO_RST;
      locked     <= 1'b0;
      pend_stop  <= 1'b0;
      pend_ratio <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A stop while idle is consumed without effect.
          if (start_clr) begin
            div_ratio  <= req_ratio;
            div_enable <= 1'b1;
            locked     <= 1'b0;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_RUN: begin
          if (accept) begin
            pend_stop  <= req_stop;
            pend_ratio <= req_ratio;
            state      <= ST_PEND;
          end
        end
        ST_PEND: begin
          // Stop waits for the high-to-low toggle so clk_out freezes low.
          if (boundary) begin
            if (pend_stop) begin
              if (div_phase) begin
                div_enable <= 1'b0;
                locked     <= 1'b0;
                pend_stop  <= 1'b0;
                state      <= ST_IDLE;
              end
            end else begin
              div_ratio  <= pend_ratio;
              locked     <= 1'b0;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (rise_edge) begin
            if (settle_cnt == SETTLE_LAST) begin
              locked     <= 1'b1;
              settle_cnt <= '0;
              state      <= ST_RUN;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
